mdu_sched: RTL

//   Multi-cycle multiply/divide scheduler beside the E-stage ALU of the P7 pipeline.

---
 rtl/mdu_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide scheduler: owns HI/LO, models iterative-unit latency with a
// down-counter and drives busy/md_stall to the hazard unit.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d;
    logic [31:0]      lo_tmp_q, lo_tmp_d;
    logic             wb_q, wb_d;

    logic        accept;
    logic        is_long;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_s_den;
    logic [31:0] div_u_den;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        res_valid;

    assign busy     = (state_q == ST_RUN);
    assign is_long  = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
    assign accept   = start & ~req & ~busy;
    assign md_stall = busy | (start & ~req & is_long);
    assign HI       = hi_q;
    assign LO       = lo_q;

    // Signed divide works on magnitudes; a zero divisor is replaced so no X reaches the result.
    always_comb begin
        prod_s    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u    = {32'd0, A} * {32'd0, B};
        a_neg     = A[31];
        b_neg     = B[31];
        a_mag     = a_neg ? (32'd0 - A) : A;
        b_mag     = b_neg ? (32'd0 - B) : B;
        div_s_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        div_u_den = (B == 32'd0) ? 32'd1 : B;
        mag_q     = a_mag / div_s_den;
        mag_r     = a_mag % div_s_den;
        quo_s     = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
        rem_s     = a_neg ? (32'd0 - mag_r) : mag_r;
        quo_u     = A / div_u_den;
        rem_u     = A % div_u_den;
    end

    always_comb begin
        hi_res    = 32'd0;
        lo_res    = 32'd0;
        res_valid = 1'b1;
        case (MDUop)
            OP_MULT: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            OP_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            OP_DIV: begin
                hi_res    = rem_s;
                lo_res    = quo_s;
                res_valid = (B != 32'd0);
            end
            OP_DIVU: begin
                hi_res    = rem_u;
                lo_res    = quo_u;
                res_valid = (B != 32'd0);
            end
            default: begin
                hi_res    = 32'd0;
                lo_res    = 32'd0;
                res_valid = 1'b0;
            end
        endcase
    end

    // A running op is never cancelled by req; it only blocks new starts via accept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wb_d     = wb_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_long) begin
                    state_d  = ST_RUN;
                    hi_tmp_d = hi_res;
                    lo_tmp_d = lo_res;
                    wb_d     = res_valid;
                    if ((MDUop == OP_MULT) || (MDUop == OP_MULTU)) begin
                        cnt_d = CNT_W'(MULT_CYCLES - 1);
                    end else begin
                        cnt_d = CNT_W'(DIV_CYCLES - 1);
                    end
                end else if (accept && (MDUop == OP_MTHI)) begin
                    hi_d = A;
                end else if (accept && (MDUop == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (wb_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            wb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wb_q     <= wb_d;
        end
    end

endmodule
